// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus bundle.
// Carries the instruction-memory request/response channel, the redirect
// input and the instruction queue output toward the fetch stage.
//   master : the fetch buffer (drives imem requests and queue output)
//   slave  : the environment (instruction memory, branch unit, fetch stage)
interface fetch_buffer_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer.
// Issues sequential word fetches to instruction memory, tags in-order
// responses with their PC and queues them in a DEPTH-entry first-word
// fall-through FIFO. Requests are credit-limited so that queued plus
// in-flight words never exceed DEPTH. A redirect flushes the queue,
// restarts fetching at the new PC and discards responses to requests
// that were already in flight.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - asynchronous active-high reset
//   bus  - fetch_buffer_if.master: imem_req_*, imem_rsp_*, redirect_*, out_*
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,
  fetch_buffer_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q,   rsp_pc_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0] occ_q,      occ_d;
  logic [CW-1:0] infl_q,     infl_d;
  logic [CW-1:0] disc_q,     disc_d;

  // Queue storage holds {pc, instr}; it is never read while empty, so it
  // carries no reset.
  logic [63:0]   mem_q [DEPTH];

  logic [CW:0]   credit_sum;
  logic          req_valid_w, out_valid_w;
  logic          req_fire, rsp_fire, push, pop;
  logic [31:0]   redirect_aligned;

  always_comb begin
    credit_sum       = {1'b0, occ_q} + {1'b0, infl_q};
    redirect_aligned = bus.redirect_pc & ~32'h3;
    // In-flight requests hold a queue slot, so the queue can never overflow.
    req_valid_w      = !rst && !bus.redirect_valid && (credit_sum < {1'b0, DEPTH_CNT});
    out_valid_w      = !rst && !bus.redirect_valid && (occ_q != '0);
    req_fire         = req_valid_w && bus.imem_req_ready;
    rsp_fire         = bus.imem_rsp_valid && !rst;
    pop              = out_valid_w && bus.out_ready;
    push             = rsp_fire && !bus.redirect_valid && (disc_q == '0);

    bus.imem_req_valid = req_valid_w;
    bus.imem_req_addr  = fetch_pc_q;
    bus.out_valid      = out_valid_w;
    bus.out_pc         = out_valid_w ? mem_q[rd_ptr_q][63:32] : '0;
    bus.out_instr      = out_valid_w ? mem_q[rd_ptr_q][31:0]  : '0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    infl_d     = infl_q;
    disc_d     = disc_q;

    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;

    case ({req_fire, rsp_fire})
      2'b10:   infl_d = infl_q + CNT_ONE;
      2'b01:   infl_d = infl_q - CNT_ONE;
      default: infl_d = infl_q;
    endcase

    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      rsp_pc_d   = redirect_aligned;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      // Every request still outstanding after this cycle belongs to the
      // old stream and must be thrown away.
      disc_d     = infl_d;
    end else begin
      if (rsp_fire && (disc_q != '0)) disc_d = disc_q - CNT_ONE;
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rsp_pc_d = rsp_pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   occ_d = occ_q + CNT_ONE;
        2'b01:   occ_d = occ_q - CNT_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      infl_q     <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      infl_q     <= infl_d;
      disc_q     <= disc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {rsp_pc_q, bus.imem_rsp_data};
  end

endmodule
